// File: rtl/modexp_pkg.sv
// modexp_pkg: shared widths, FSM encoding and multiplication-count helper for modexp_ctrl
package modexp_pkg;
  localparam int N_DEF = 512;
  localparam int E_W_DEF = 512;
  localparam int MM_EXTRA = 2;
  typedef enum logic [2:0] {IDLE, CONV_X, SQR, MUL, POST, FIN} state_t;
  function automatic int mm_count(input int e_w, input int ones);
    return e_w + ones + MM_EXTRA;
  endfunction
endpackage

// File: rtl/modexp_ctrl.sv
// modexp_ctrl: left-to-right square-and-multiply sequencer driving an external Montgomery core
module modexp_ctrl
  import modexp_pkg::*;
#(
  parameter int N = N_DEF,
  parameter int E_W = E_W_DEF
) (
  input  logic           clk,
  input  logic           resetn,
  input  logic           start,
  input  logic [N-1:0]   in_x,
  input  logic [E_W-1:0] in_e,
  input  logic [N-1:0]   in_m,
  input  logic [N-1:0]   in_r,
  input  logic [N-1:0]   in_r2,
  output logic           mm_start,
  output logic [N-1:0]   mm_a,
  output logic [N-1:0]   mm_b,
  output logic [N-1:0]   mm_m,
  input  logic [N-1:0]   mm_result,
  input  logic           mm_done,
  output logic [N-1:0]   result,
  output logic           done,
  output logic           busy
);
  localparam int CW = $clog2(E_W) + 1;
  state_t state, state_n;
  logic waiting, issuing, take, last, bit_hi;
  logic [N-1:0] acc, xm, m, r2;
  logic [E_W-1:0] e_sh;
  logic [CW-1:0] cnt;
  // operand muxing, handshake decode and next state
  always_comb begin
    issuing = state inside {CONV_X, SQR, MUL, POST};
    mm_start = issuing && !waiting;
    take = issuing && waiting && mm_done;
    last = cnt == CW'(1);
    bit_hi = e_sh[E_W-1];
    mm_a = state == CONV_X ? xm : acc;
    mm_b = state == CONV_X ? r2 : state == SQR ? acc : state == MUL ? xm : N'(1);
    mm_m = m;
    busy = state != IDLE;
    done = state == FIN;
    state_n = state;
    case (state)
      IDLE:    state_n = start ? CONV_X : IDLE;
      CONV_X:  state_n = take ? SQR : CONV_X;
      SQR:     state_n = !take ? SQR : bit_hi ? MUL : last ? POST : SQR;
      MUL:     state_n = !take ? MUL : last ? POST : SQR;
      POST:    state_n = take ? FIN : POST;
      FIN:     state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end
  // state register
  always_ff @(posedge clk) state <= !resetn ? IDLE : state_n;
  // tracks whether the current state's multiplication is in flight
  always_ff @(posedge clk) waiting <= !resetn ? 1'b0 : take ? 1'b0 : mm_start ? 1'b1 : waiting;
  // operand latch, accumulator, exponent shifter and bit counter
  always_ff @(posedge clk) begin
    if (!resetn) begin
      acc <= '0;
      xm <= '0;
      m <= '0;
      r2 <= '0;
      e_sh <= '0;
      cnt <= '0;
      result <= '0;
    end else if (state == IDLE && start) begin
      xm <= in_x;
      r2 <= in_r2;
      m <= in_m;
      acc <= in_r;
      e_sh <= in_e;
      cnt <= CW'(E_W);
    end else if (take) begin
      if (state == CONV_X) xm <= mm_result;
      else acc <= mm_result;
      if (state == POST) result <= mm_result;
      if ((state == SQR && !bit_hi) || state == MUL) begin
        e_sh <= e_sh << 1;
        cnt <= cnt - 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_modexp_ctrl.sv
// tb_modexp_ctrl: directed scoreboard bench with a 5-cycle Montgomery core model
module tb_modexp_ctrl;
  localparam int N = 512;
  localparam int E_W = 8;
  logic clk = 0, resetn = 0, start = 0, spur = 0;
  logic [N-1:0] in_x = '0, in_m = '0, in_r = '0, in_r2 = '0;
  logic [E_W-1:0] in_e = '0;
  logic mm_start, mm_done, done, busy;
  logic [N-1:0] mm_a, mm_b, mm_m, mm_result, result;
  logic [N-1:0] ca = '0, cb = '0, cm = '0, core_res = '0;
  logic core_done = 0;
  int ccnt = 0;
  int checks = 0, errors = 0;
  logic [N-1:0] exp_q[$];

  modexp_ctrl #(.N(N), .E_W(E_W)) dut (
    .clk(clk), .resetn(resetn), .start(start), .in_x(in_x), .in_e(in_e), .in_m(in_m),
    .in_r(in_r), .in_r2(in_r2), .mm_start(mm_start), .mm_a(mm_a), .mm_b(mm_b), .mm_m(mm_m),
    .mm_result(mm_result), .mm_done(mm_done), .result(result), .done(done), .busy(busy)
  );

  always #5 clk = ~clk;

  function automatic logic [N-1:0] mont(input logic [N-1:0] a, input logic [N-1:0] b, input logic [N-1:0] m);
    logic [N+1:0] t = '0;
    for (int i = 0; i < N; i++) begin
      if (a[i]) t = t + {2'b00, b};
      if (t[0]) t = t + {2'b00, m};
      t = t >> 1;
    end
    if (t >= {2'b00, m}) t = t - {2'b00, m};
    return t[N-1:0];
  endfunction

  function automatic int pow_mod(input int x, input int e, input int m);
    int r = 1 % m;
    for (int i = 0; i < e; i++) r = (r * x) % m;
    return r;
  endfunction

  function automatic int r_mod(input int m);
    int r = 1 % m;
    for (int i = 0; i < N; i++) r = (r * 2) % m;
    return r;
  endfunction

  always @(posedge clk) begin
    core_done <= 1'b0;
    if (mm_start) begin
      ca <= mm_a;
      cb <= mm_b;
      cm <= mm_m;
      ccnt <= 5;
    end else if (ccnt > 0) begin
      ccnt <= ccnt - 1;
      if (ccnt == 1) begin
        core_done <= 1'b1;
        core_res <= mont(ca, cb, cm);
      end
    end
  end
  assign mm_done = core_done | spur;
  assign mm_result = core_res;

  task automatic check(input string tag, input logic [N-1:0] obs, input logic [N-1:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  task automatic run_op(input string tag, input int x, input int e, input int m, input bit hammer, input bit spur_mid);
    int r = r_mod(m);
    int starts = 0, extra = 0;
    bit seen = 0, spurred = 0;
    logic [N-1:0] res_done = '0, expv;
    exp_q.push_back(N'(pow_mod(x, e, m)));
    @(negedge clk);
    in_x = N'(x); in_e = E_W'(e); in_m = N'(m); in_r = N'(r); in_r2 = N'((r * r) % m);
    start = 1;
    @(negedge clk);
    check({tag, "_busy_hi"}, N'(busy), N'(1));
    if (!hammer) start = 0;
    in_x = N'($urandom); in_e = E_W'($urandom); in_m = N'($urandom); in_r = N'($urandom); in_r2 = N'($urandom);
    for (int cyc = 0; cyc < 3000 && !seen; cyc++) begin
      if (mm_start) starts++;
      if (mm_start && starts == 1) check({tag, "_mm_m"}, mm_m, N'(m));
      if (spur_mid && mm_start && !spurred) begin spur = 1; spurred = 1; end
      if (done) begin seen = 1; res_done = result; start = 0; end
      @(negedge clk);
      spur = 0;
    end
    check({tag, "_done_seen"}, N'(seen), N'(1));
    expv = exp_q.pop_front();
    check({tag, "_result"}, res_done, expv);
    check({tag, "_busy_lo"}, N'(busy), N'(0));
    check({tag, "_mm_count"}, N'(starts), N'(E_W + $countones(E_W'(e)) + 2));
    for (int i = 0; i < 10; i++) begin
      if (mm_start || done) extra++;
      @(negedge clk);
    end
    check({tag, "_no_extra"}, N'(extra), N'(0));
    check({tag, "_hold"}, result, expv);
  endtask

  initial begin
    int dn = 0, late = 0;
    repeat (3) @(negedge clk);
    check("rst_busy", N'(busy), N'(0));
    check("rst_done", N'(done), N'(0));
    check("rst_mm_start", N'(mm_start), N'(0));
    check("rst_result", result, N'(0));
    resetn = 1;
    @(negedge clk); spur = 1;
    @(negedge clk); spur = 0;
    @(negedge clk);
    check("idle_spur_busy", N'(busy), N'(0));
    check("idle_spur_result", result, N'(0));
    run_op("x3e5", 3, 5, 13, 0, 0);
    run_op("x2eff", 2, 255, 13, 0, 0);
    run_op("x7e0", 7, 0, 13, 0, 0);
    run_op("x0e5", 0, 5, 13, 0, 0);
    run_op("m1e0", 4, 0, 1, 0, 0);
    run_op("hammer", 3, 5, 13, 1, 0);
    @(negedge clk);
    in_x = N'(3); in_e = E_W'(5); in_m = N'(13); in_r = N'(r_mod(13)); in_r2 = N'((r_mod(13) * r_mod(13)) % 13);
    start = 1;
    @(negedge clk);
    start = 0;
    for (int cyc = 0; cyc < 3000 && dn < 4; cyc++) begin
      if (core_done) dn++;
      if (dn < 4) @(negedge clk);
    end
    check("abort_reach4", N'(dn), N'(4));
    resetn = 0;
    @(negedge clk);
    resetn = 1;
    check("abort_busy", N'(busy), N'(0));
    check("abort_result", result, N'(0));
    spur = 1;
    @(negedge clk);
    spur = 0;
    for (int i = 0; i < 20; i++) begin
      if (done || busy) late++;
      @(negedge clk);
    end
    check("abort_no_done", N'(late), N'(0));
    run_op("x5e3", 5, 3, 13, 0, 0);
    run_op("spur_mid", 3, 5, 13, 0, 1);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/modexp_ctrl.md
MODEXP_CTRL -- requirements
Module: modexp_ctrl

Interface
REQ-001 Parameter N, 512, operand/modulus width; it SHALL equal the Montgomery core width.
REQ-002 Parameter E_W, 512, exponent width; exponent scan counter width SHALL be clog2(E_W)+1.
REQ-003 clk  in  1  clock; all state changes SHALL occur on its rising edge.
REQ-004 resetn  in  1  reset, synchronous, active-low.
REQ-005 start  in  1  one-cycle request; sampled only in IDLE.
REQ-006 in_x  in  N  base, normal domain, in_x < in_m.
REQ-007 in_e  in  E_W  exponent.
REQ-008 in_m  in  N  odd modulus.
REQ-009 in_r  in  N  R mod M, R = 2^N.
REQ-010 in_r2  in  N  R^2 mod M.
REQ-011 mm_start  out  1  one-cycle start pulse to the Montgomery core.
REQ-012 mm_a, mm_b, mm_m  out  N each  core operands.
REQ-013 mm_result  in  N  core product a*b*R^-1 mod M.
REQ-014 mm_done  in  1  one-cycle core completion pulse.
REQ-015 result  out  N  x^e mod M.
REQ-016 done  out  1  one-cycle completion pulse.
REQ-017 busy  out  1  high from the cycle after start is accepted until the cycle done pulses.

Function
REQ-018 Accepting start in IDLE SHALL latch in_x, in_e, in_m, in_r, in_r2; later input changes SHALL NOT affect the operation.
REQ-019 FSM states SHALL be: IDLE, CONV_X, SQR, MUL, POST, FIN.
- Each non-IDLE/FIN state issues one multiplication, then waits for mm_done.
REQ-020 CONV_X SHALL compute xm = MM(x, r2) and set acc = r.
REQ-021 Exponent bits SHALL be scanned MSB to LSB over all E_W bits, with no leading-zero skip.
- Per bit: SQR computes acc = MM(acc, acc).
- If the bit is 1, MUL then computes acc = MM(acc, xm).
REQ-022 After bit 0, POST SHALL compute acc = MM(acc, 1), then enter FIN.
REQ-023 FIN SHALL drive result = acc and pulse done for one cycle, then return to IDLE.
REQ-024 mm_start SHALL pulse exactly one cycle per multiplication, in the first cycle of each issuing state.
REQ-025 mm_a, mm_b, mm_m SHALL be valid in the mm_start cycle and held stable until mm_done.
REQ-026 mm_result SHALL be captured only on mm_done while waiting; mm_done at any other time SHALL be ignored.
REQ-027 Multiplications per operation SHALL equal E_W + popcount(e) + 2.
REQ-028 Controller overhead SHALL be at most 2 cycles per multiplication beyond core latency.
REQ-029 start while busy SHALL be ignored; no queuing.
REQ-030 Edge cases:
- e = 0 SHALL yield result = 1 (or 0 when M = 1).
- x = 0 with e != 0 SHALL yield 0.
REQ-031 result SHALL hold its value until the next FIN.

Reset
REQ-032 With resetn low at a clock edge:
- state SHALL go to IDLE.
- mm_start, done and busy SHALL go to 0.
- result, acc, xm and the counter SHALL go to 0.
REQ-033 Reset mid-operation SHALL abandon the operation with no done pulse; a late mm_done afterwards SHALL be ignored.

Structure
REQ-034 Shared package modexp_pkg SHALL hold N, E_W defaults, state encodings and the MM-count formula constant.
REQ-035 The Montgomery core SHALL stay external so it can later be shared.
REQ-036 No sub-module is required; the exponent shift register and counter SHALL be inline.

Verification (bench core model: MM(a,b) = a*b*R^-1 mod M, latency 5 cycles; E_W = 8; R = 2^512)
REQ-037 x=3, e=5, m=13 -> result 9, one done pulse, exactly 12 mm_start pulses.
REQ-038 x=2, e=0xFF, m=13 -> result 8, 18 mm_start pulses.
REQ-039 x=7, e=0, m=13 -> result 1, 10 mm_start pulses.
REQ-040 start re-asserted every cycle during x=3, e=5, m=13 -> single operation, result 9, second start ignored until busy is low.
REQ-041 resetn low for 1 cycle at the 4th mm_done -> busy 0, no done pulse; the next start with x=5, e=3, m=13 -> result 8.
REQ-042 Spurious mm_done in IDLE and mid-issue -> no state change and no result corruption; x=3, e=5 still gives 9.
